// File: rtl/obi_data_responder.sv
// obi_data_responder
// ------------------
// Memory-side responder for the core's OBI-style data port. It is a
// word-organised data RAM with byte-enable writes. It serves one
// transaction at a time, with a programmable grant delay (GNT_DELAY) and
// response latency (RVALID_LATENCY).
//
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset (also clears the whole RAM)
//   req_i     request valid, held by the master until granted
//   gnt_o     grant; accept happens on a rising edge with req_i && gnt_o
//   addr_i    byte address
//   we_i      1 = write, 0 = read
//   be_i      byte enables, used for write lanes only
//   wdata_i   write data
//   rvalid_o  one-cycle response strobe
//   rdata_o   read data (valid with rvalid_o, holds its last value otherwise)
//   err_o     error flag (valid with rvalid_o, 0 otherwise)

module obi_data_responder #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    MEM_DEPTH      = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    GNT_DELAY      = 0,
  parameter int                    RVALID_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o
);

  localparam int                    NUM_LANES   = DATA_WIDTH / 8;
  localparam int                    IDX_W       = $clog2(MEM_DEPTH);
  localparam logic [3:0]            GNT_DELAY_C = 4'(GNT_DELAY);
  localparam logic [3:0]            LAT_C       = 4'(RVALID_LATENCY);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_C     = ADDR_WIDTH'(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    RESP
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic [3:0]            lat_cnt_q, lat_cnt_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] word_off;
  logic [IDX_W-1:0]      idx;
  logic                  addr_err;
  logic                  accept;
  logic                  resp_fire;

  // Address decode. The range check uses the full word offset so that
  // addresses far above the RAM cannot alias onto a valid index.
  always_comb begin
    offset   = addr_i - BASE_ADDR;
    word_off = offset >> 2;
    idx      = word_off[IDX_W-1:0];
    addr_err = (addr_i < BASE_ADDR) || (word_off >= DEPTH_C) ||
               (addr_i[1:0] != 2'b00);
  end

  // The response cycle is the last RESP cycle; outputs are qualified by it.
  assign resp_fire = (state_q == RESP) && (lat_cnt_q == LAT_C);
  assign rvalid_o  = resp_fire;
  assign err_o     = resp_fire && resp_err_q;
  assign rdata_o   = resp_fire ? resp_data_q : rdata_q;

  // Handshake FSM. gnt_o is decoded from state and counters; an accepted
  // request overrides the per-state next values and starts the response.
  // The response word is snapshot at accept so later writes cannot alter it.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    gnt_o       = 1'b0;
    accept      = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_o = req_i && (GNT_DELAY_C == 4'd0);
        if (req_i && !gnt_o) begin
          state_d    = WAIT_GNT;
          wait_cnt_d = 4'd1;
        end
      end
      WAIT_GNT: begin
        gnt_o = req_i && (wait_cnt_q == GNT_DELAY_C);
        if (!req_i) begin
          // Request withdrawn before grant: abandon it without side effects.
          state_d    = IDLE;
          wait_cnt_d = 4'd0;
        end else if (!gnt_o) begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (lat_cnt_q == LAT_C) begin
          state_d   = IDLE;
          lat_cnt_d = 4'd0;
        end else begin
          lat_cnt_d = lat_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    accept = gnt_o;
    if (accept) begin
      state_d     = RESP;
      lat_cnt_d   = 4'd1;
      wait_cnt_d  = 4'd0;
      resp_err_d  = addr_err;
      resp_data_d = (addr_err || we_i) ? '0 : mem_q[idx];
    end
  end

  // rdata_o keeps the last delivered word between responses.
  always_comb begin
    rdata_d = resp_fire ? resp_data_q : rdata_q;
  end

  // Byte-lane write, performed at the accept edge of an error-free write.
  always_comb begin
    mem_d = mem_q;
    if (accept && we_i && !addr_err) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (be_i[k]) begin
          mem_d[idx][8*k +: 8] = wdata_i[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 4'd0;
      lat_cnt_q   <= 4'd0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      rdata_q     <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      rdata_q     <= rdata_d;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_obi_data_responder.sv
// Testbench for obi_data_responder. Three instances with different timing
// parameters share clock, reset and request payload; each has its own req.
//   inst 0: GNT_DELAY=0, RVALID_LATENCY=1
//   inst 1: GNT_DELAY=3, RVALID_LATENCY=4
//   inst 2: GNT_DELAY=0, RVALID_LATENCY=3
// Only one instance is active at a time, so one in-order scoreboard serves all.

module tb_obi_data_responder;

  logic        clk;
  logic        rst_n;
  logic        req    [3];
  logic        gnt    [3];
  logic        rvalid [3];
  logic        err    [3];
  logic [31:0] rdata  [3];
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;

  int tests    = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          inst;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  obi_data_responder #(.GNT_DELAY(0), .RVALID_LATENCY(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .err_o(err[0]));

  obi_data_responder #(.GNT_DELAY(3), .RVALID_LATENCY(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .err_o(err[1]));

  obi_data_responder #(.GNT_DELAY(0), .RVALID_LATENCY(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid[2]),
    .rdata_o(rdata[2]), .err_o(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int latOf(input int k);
    case (k)
      0:       return 1;
      1:       return 4;
      default: return 3;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issues one request on instance k (called just after a rising edge),
  // waits for the grant, checks how many cycles the grant took, and pushes
  // the expected response with the cycle in which rvalid must appear.
  task automatic applyStimulus(input int k, input logic w, input logic [31:0] a,
                               input logic [3:0] b, input logic [31:0] d,
                               input int expGnt, input logic [31:0] expData,
                               input logic expErr, input bit push);
    int   waited  = 0;
    bit   granted = 0;
    exp_t e;
    we = w; addr = a; be = b; wdata = d;
    req[k] = 1'b1;
    while (!granted && waited <= 40) begin
      @(negedge clk);
      if (gnt[k]) granted = 1;
      else        waited++;
    end
    if (!granted) begin
      tests++;
      failures++;
      $display("[TB] FAIL gnt_timeout inst %0d addr 0x%08h: no grant in %0d cycles, expected after %0d",
               k, a, waited, expGnt);
      req[k] = 1'b0;
    end else begin
      checkOutput("gnt_delay", waited, expGnt);
      if (push) begin
        e.inst = k;
        e.data = expData;
        e.err  = expErr;
        e.cyc  = cyc + latOf(k);
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      req[k] = 1'b0;
    end
  endtask

  // Monitor: every rvalid pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (rvalid[k]) begin
          if (sb.size() == 0) begin
            tests++;
            failures++;
            $display("[TB] FAIL unexpected_rvalid inst %0d: rdata 0x%08h err %0b, no response expected (cycle %0d)",
                     k, rdata[k], err[k], cyc);
          end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("resp_inst", k, e.inst);
            checkOutput("rdata", rdata[k], e.data);
            checkOutput("err", {31'd0, err[k]}, {31'd0, e.err});
            checkOutput("rvalid_cycle", cyc, e.cyc);
            checkOutput("gnt_during_resp", {31'd0, gnt[k]}, 32'd0);
          end
        end
      end
    end
  end

  initial begin
    int drain;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) req[k] = 1'b0;
    addr = '0; we = 1'b0; be = '0; wdata = '0;

    // Reset values
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checkOutput("reset_rvalid", {31'd0, rvalid[k]}, 32'd0);
      checkOutput("reset_rdata", rdata[k], 32'd0);
      checkOutput("reset_err", {31'd0, err[k]}, 32'd0);
      checkOutput("reset_gnt", {31'd0, gnt[k]}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // inst 0: full write then read, partial write, errors, be=0 write
    applyStimulus(0, 1'b1, 32'h8,   4'hF, 32'hDEADBEEF, 0, 32'h0,        1'b0, 1);
    applyStimulus(0, 1'b0, 32'h8,   4'h0, 32'h0,        1, 32'hDEADBEEF, 1'b0, 1);
    applyStimulus(0, 1'b1, 32'h10,  4'hF, 32'h11223344, 1, 32'h0,        1'b0, 1);
    applyStimulus(0, 1'b1, 32'h10,  4'h5, 32'hAABBCCDD, 1, 32'h0,        1'b0, 1);
    applyStimulus(0, 1'b0, 32'h10,  4'hF, 32'h0,        1, 32'h11BB33DD, 1'b0, 1);
    applyStimulus(0, 1'b0, 32'h100, 4'hF, 32'h0,        1, 32'h0,        1'b1, 1);
    applyStimulus(0, 1'b1, 32'h6,   4'hF, 32'hFFFFFFFF, 1, 32'h0,        1'b1, 1);
    applyStimulus(0, 1'b0, 32'h4,   4'hF, 32'h0,        1, 32'h0,        1'b0, 1);
    applyStimulus(0, 1'b1, 32'h8,   4'h0, 32'h12345678, 1, 32'h0,        1'b0, 1);
    applyStimulus(0, 1'b0, 32'h8,   4'hF, 32'h0,        1, 32'hDEADBEEF, 1'b0, 1);
    applyStimulus(0, 1'b1, 32'h0,   4'hF, 32'h0BADF00D, 1, 32'h0,        1'b0, 1);
    idle(3);

    // inst 0: back-to-back reads with req held high
    applyStimulus(0, 1'b0, 32'h8,   4'hF, 32'h0, 0, 32'hDEADBEEF, 1'b0, 1);
    applyStimulus(0, 1'b0, 32'h10,  4'hF, 32'h0, 1, 32'h11BB33DD, 1'b0, 1);
    applyStimulus(0, 1'b0, 32'h4,   4'hF, 32'h0, 1, 32'h0,        1'b0, 1);
    applyStimulus(0, 1'b0, 32'h0,   4'hF, 32'h0, 1, 32'h0BADF00D, 1'b0, 1);
    idle(3);

    // inst 1: request withdrawn before grant has no effect
    we = 1'b1; addr = 32'h20; be = 4'hF; wdata = 32'hCAFEF00D;
    req[1] = 1'b1;
    @(negedge clk);
    checkOutput("drop_gnt_c0", {31'd0, gnt[1]}, 32'd0);
    @(negedge clk);
    checkOutput("drop_gnt_c1", {31'd0, gnt[1]}, 32'd0);
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    idle(10);

    // inst 1: delayed grant and long latency
    applyStimulus(1, 1'b0, 32'h20, 4'hF, 32'h0,        3, 32'h0,        1'b0, 1);
    idle(6);
    applyStimulus(1, 1'b1, 32'h24, 4'hF, 32'h13579BDF, 3, 32'h0,        1'b0, 1);
    idle(6);
    applyStimulus(1, 1'b0, 32'h24, 4'hF, 32'h0,        3, 32'h13579BDF, 1'b0, 1);
    idle(6);

    // inst 2: reset while a read is pending drops it and clears memory
    applyStimulus(2, 1'b1, 32'h4, 4'hF, 32'h00000055, 0, 32'h0,        1'b0, 1);
    applyStimulus(2, 1'b0, 32'h4, 4'hF, 32'h0,        3, 32'h00000055, 1'b0, 1);
    applyStimulus(2, 1'b0, 32'h4, 4'hF, 32'h0,        3, 32'h0,        1'b0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(6);
    checkOutput("post_reset_rdata", rdata[2], 32'd0);
    applyStimulus(2, 1'b0, 32'h4, 4'hF, 32'h0, 0, 32'h0, 1'b0, 1);
    applyStimulus(2, 1'b0, 32'h8, 4'hF, 32'h0, 3, 32'h0, 1'b0, 1);

    // Wait for outstanding responses, bounded
    drain = 0;
    while (sb.size() != 0 && drain < 30) begin
      @(posedge clk);
      drain++;
    end
    idle(3);
    checkOutput("scoreboard_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
